// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-rate arithmetic.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   function automatic int bit_cycles(input int clock_freq, input int baud);
      return clock_freq / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving from another clock domain.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: mid-bit sampling, one-entry valid/ready output buffer,
// framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE  = 9600,
   parameter int CLOCK_FREQ = 50000000,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int BIT_CYCLES  = bit_cycles(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam int BIT_W       = $clog2(DATA_BITS);

   // Handshake: a word transfers on every clock edge where rx_valid & rx_ready;
   // rx_valid never waits on rx_ready, and a new word overwrites an unread one.

   logic                 rx_s;
   rx_state_t            state, state_n;
   logic [CNT_W-1:0]     clock_count, clock_count_n;
   logic [BIT_W-1:0]     bit_count, bit_count_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 commit, commit_n;
   logic                 frame_err_n;

   sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         clock_count <= '0;
         bit_count   <= '0;
         shift       <= '0;
         commit      <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_n;
         clock_count <= clock_count_n;
         bit_count   <= bit_count_n;
         shift       <= shift_n;
         commit      <= commit_n;
         frame_err   <= frame_err_n;
      end
   end

   always_comb begin
      state_n       = state;
      clock_count_n = clock_count + 1'b1;
      bit_count_n   = bit_count;
      shift_n       = shift;
      commit_n      = 1'b0;
      frame_err_n   = 1'b0;
      case (state)
         IDLE: begin
            clock_count_n = '0;
            bit_count_n   = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (clock_count == CNT_W'(HALF_CYCLES - 1)) begin
               clock_count_n = '0;
               state_n       = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clock_count == CNT_W'(BIT_CYCLES - 1)) begin
               clock_count_n      = '0;
               shift_n[bit_count] = rx_s;
               if (bit_count == BIT_W'(DATA_BITS - 1)) begin
                  bit_count_n = '0;
                  state_n     = STOP;
               end else begin
                  bit_count_n = bit_count + 1'b1;
               end
            end
         end
         STOP: begin
            if (clock_count == CNT_W'(BIT_CYCLES - 1)) begin
               clock_count_n = '0;
               if (rx_s) begin
                  commit_n = 1'b1;
                  state_n  = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = BREAK;
               end
            end
         end
         BREAK: begin
            clock_count_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            clock_count_n = '0;
            state_n       = IDLE;
         end
      endcase
   end

   assign rx_busy = (state != IDLE);

   // A commit coinciding with an accept replaces the consumed word without an overrun.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (commit) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            overrun  <= rx_valid & ~rx_ready;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
